load_store_unit: RTL and testbench

//  Initiator side of the data-memory port: accepts one load/store request at a time from the CPU

---
 rtl/load_store_unit.sv | 189 ++++++++++++++++++
 tb/tb_load_store_unit.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: single-outstanding request initiator for a word-addressed data memory.
// Sub-word loads extract and extend a lane; sub-word stores do read-modify-write.
module load_store_unit #(
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_misaligned,
  output logic        resp_oob,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_read_data
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      r_state;
  state_t      w_next;

  logic        r_write;
  logic [1:0]  r_size;
  logic        r_signed;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_mem_wdata;
  logic [31:0] r_rdata;
  logic        r_mis;
  logic        r_oob;

  logic        w_accept;
  logic        w_mis;
  logic        w_oob;
  logic [4:0]  w_shamt;
  logic [31:0] w_lane;
  logic [31:0] w_load_val;
  logic [31:0] w_mask;
  logic [31:0] w_merged;

  assign w_accept = req_valid & req_ready;

  // Request checks on the live request; only meaningful at the accept edge.
  always_comb begin
    w_mis = 1'b0;
    case (req_size)
      SZ_BYTE: w_mis = 1'b0;
      SZ_HALF: w_mis = req_addr[0];
      SZ_WORD: w_mis = (req_addr[1:0] != 2'b00);
      default: w_mis = 1'b1;
    endcase
  end

  assign w_oob = ((req_addr >> ADDR_BITS) != '0);

  // Lane shift is valid for halves/words too because accepted requests are aligned.
  assign w_shamt = {r_addr[1:0], 3'b000};
  assign w_lane  = mem_read_data >> w_shamt;

  always_comb begin
    w_load_val = w_lane;
    case (r_size)
      SZ_BYTE: w_load_val = {{24{r_signed & w_lane[7]}}, w_lane[7:0]};
      SZ_HALF: w_load_val = {{16{r_signed & w_lane[15]}}, w_lane[15:0]};
      default: w_load_val = w_lane;
    endcase
  end

  always_comb begin
    w_mask = '0;
    case (r_size)
      SZ_BYTE: w_mask = 32'h0000_00FF << w_shamt;
      SZ_HALF: w_mask = 32'h0000_FFFF << w_shamt;
      default: w_mask = '1;
    endcase
  end

  assign w_merged = (mem_read_data & ~w_mask) | ((r_wdata << w_shamt) & w_mask);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_mis || w_oob) begin
            w_next = S_RESP;
          end else if (req_write && (req_size == SZ_WORD)) begin
            w_next = S_WRITE;
          end else begin
            w_next = S_READ;
          end
        end
      end
      S_READ:  w_next = r_write ? S_WRITE : S_RESP;
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Latched request and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_write     <= 1'b0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_mis       <= 1'b0;
      r_oob       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write  <= req_write;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_rdata  <= '0;
        r_mis    <= w_mis;
        r_oob    <= w_oob & ~w_mis;
        if (req_write && (req_size == SZ_WORD)) begin
          r_mem_wdata <= req_wdata;
        end
      end else if (r_state == S_READ) begin
        if (r_write) begin
          r_mem_wdata <= w_merged;
        end else begin
          r_rdata <= w_load_val;
        end
      end
    end
  end

  // Output logic; handshake and memory strobes are gated by reset combinationally
  always_comb begin
    req_ready       = 1'b0;
    mem_read        = 1'b0;
    mem_write       = 1'b0;
    resp_valid      = 1'b0;
    resp_misaligned = 1'b0;
    resp_oob        = 1'b0;
    case (r_state)
      S_IDLE:  req_ready = rst_n;
      S_READ:  mem_read  = rst_n;
      S_WRITE: mem_write = rst_n;
      S_RESP: begin
        resp_valid      = 1'b1;
        resp_misaligned = r_mis;
        resp_oob        = r_oob;
      end
      default: req_ready = 1'b0;
    endcase
  end

  assign resp_rdata     = r_rdata;
  assign mem_address    = {r_addr[31:2], 2'b00};
  assign mem_write_data = r_mem_wdata;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 256-word sync-write / comb-read memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        resp_oob;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_read_data;

  logic [31:0] mem [256];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_BITS(10)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .req_valid       (req_valid),
    .req_ready       (req_ready),
    .req_write       (req_write),
    .req_size        (req_size),
    .req_signed      (req_signed),
    .req_addr        (req_addr),
    .req_wdata       (req_wdata),
    .resp_valid      (resp_valid),
    .resp_rdata      (resp_rdata),
    .resp_misaligned (resp_misaligned),
    .resp_oob        (resp_oob),
    .mem_address     (mem_address),
    .mem_write_data  (mem_write_data),
    .mem_write       (mem_write),
    .mem_read        (mem_read),
    .mem_read_data   (mem_read_data)
  );

  assign mem_read_data = mem[mem_address[9:2]];

  always @(posedge clk) begin
    if (mem_write) mem[mem_address[9:2]] <= mem_write_data;
  end

  // One request: returns response fields, accept-to-resp latency and memory strobe activity.
  task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] rd, output logic mis, output logic oob,
                        output int lat, output int nrd, output int nwr,
                        output logic [31:0] waddr, output logic [31:0] wdat);
    int n;
    rd = '0; mis = 1'b0; oob = 1'b0; lat = 0; nrd = 0; nwr = 0; waddr = '0; wdat = '0;
    @(negedge clk);
    req_write = wr; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout: req_ready=%0b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_write = ~wr; req_size = 2'b11; req_signed = ~sg;
    req_addr = 32'hFFFF_FFFF; req_wdata = $urandom;
    while (lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_read) nrd++;
      if (mem_write) begin
        nwr++; waddr = mem_address; wdat = mem_write_data;
      end
      if (resp_valid) begin
        rd = resp_rdata; mis = resp_misaligned; oob = resp_oob;
        break;
      end
    end
    if (!resp_valid) begin
      checks++; errors++;
      $display("FAIL resp_timeout: resp_valid=%0b required 1", resp_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10;
    req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h1111_1111;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (req_ready !== 1'b0) begin
        errors++; $display("FAIL reset_ready: got %0b required 0", req_ready);
      end
      checks++;
      if (mem_write !== 1'b0) begin
        errors++; $display("FAIL reset_mem_write: got %0b required 0", mem_write);
      end
    end
    req_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL post_reset_ready: got %0b required 1", req_ready);
    end
    checks++;
    if ({resp_valid, resp_misaligned, resp_oob, mem_read, mem_write} !== 5'b0 ||
        resp_rdata !== 32'h0 || mem_address !== 32'h0 || mem_write_data !== 32'h0) begin
      errors++;
      $display("FAIL post_reset_outputs: rv=%0b mis=%0b oob=%0b mr=%0b mw=%0b rdata=%h addr=%h wdata=%h required all 0",
               resp_valid, resp_misaligned, resp_oob, mem_read, mem_write, resp_rdata, mem_address, mem_write_data);
    end
    checks++;
    if (mem[4] !== 32'h0) begin
      errors++; $display("FAIL reset_no_write: mem[0x10]=%h required 00000000", mem[4]);
    end
  endtask

  task automatic test_word_store_load();
    logic [31:0] rd, wa, wdt; logic mis, oob; int lat, nrd, nwr;
    do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (lat !== 2 || nwr !== 1 || nrd !== 0) begin
      errors++; $display("FAIL sw_timing: lat=%0d writes=%0d reads=%0d required 2/1/0", lat, nwr, nrd);
    end
    checks++;
    if (wa !== 32'h10 || wdt !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_write: addr=%h data=%h required 00000010/deadbeef", wa, wdt);
    end
    checks++;
    if (rd !== 32'h0 || mis !== 1'b0 || oob !== 1'b0) begin
      errors++; $display("FAIL sw_resp: rdata=%h mis=%0b oob=%0b required 0/0/0", rd, mis, oob);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (rd !== 32'hDEAD_BEEF || lat !== 2 || nrd !== 1 || nwr !== 0) begin
      errors++; $display("FAIL lw: rdata=%h lat=%0d reads=%0d writes=%0d required deadbeef/2/1/0", rd, lat, nrd, nwr);
    end
  endtask

  task automatic test_subword_loads();
    logic [31:0] rd, wa, wdt; logic mis, oob; int lat, nrd, nwr;
    logic        wr_v [4] = '{1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  sz_v [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        sg_v [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ad_v [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
    logic [31:0] ex_v [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
    for (int i = 0; i < 4; i++) begin
      do_req(wr_v[i], sz_v[i], sg_v[i], ad_v[i], 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
      checks++;
      if (rd !== ex_v[i] || lat !== 2 || mis !== 1'b0 || oob !== 1'b0) begin
        errors++;
        $display("FAIL subword_load_%0d: rdata=%h lat=%0d mis=%0b oob=%0b required %h/2/0/0", i, rd, lat, mis, oob, ex_v[i]);
      end
    end
  endtask

  task automatic test_byte_store_rmw();
    logic [31:0] rd, wa, wdt; logic mis, oob; int lat, nrd, nwr;
    do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'hAAAA_AA55, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (lat !== 3 || nrd !== 1 || nwr !== 1) begin
      errors++; $display("FAIL sb_timing: lat=%0d reads=%0d writes=%0d required 3/1/1", lat, nrd, nwr);
    end
    checks++;
    if (wdt !== 32'hDEAD_55EF || wa !== 32'h10 || rd !== 32'h0) begin
      errors++; $display("FAIL sb_write: data=%h addr=%h rdata=%h required dead55ef/00000010/0", wdt, wa, rd);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (rd !== 32'hDEAD_55EF) begin
      errors++; $display("FAIL sb_readback: rdata=%h required dead55ef", rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd, wa, wdt; logic mis, oob; int lat, nrd, nwr;
    do_req(1'b0, 2'b10, 1'b0, 32'h06, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (mis !== 1'b1 || oob !== 1'b0 || lat !== 1 || nrd !== 0 || nwr !== 0 || rd !== 32'h0) begin
      errors++; $display("FAIL misaligned_lw: mis=%0b oob=%0b lat=%0d reads=%0d writes=%0d rdata=%h required 1/0/1/0/0/0",
                         mis, oob, lat, nrd, nwr, rd);
    end
    checks++;
    if (req_ready !== 1'b0) begin
      errors++; $display("FAIL ready_in_resp: got %0b required 0", req_ready);
    end
    do_req(1'b1, 2'b10, 1'b0, 32'h400, 32'h1234_5678, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (oob !== 1'b1 || mis !== 1'b0 || lat !== 1 || nrd !== 0 || nwr !== 0) begin
      errors++; $display("FAIL oob_sw: oob=%0b mis=%0b lat=%0d reads=%0d writes=%0d required 1/0/1/0/0", oob, mis, lat, nrd, nwr);
    end
    do_req(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (mis !== 1'b1 || nrd !== 0 || lat !== 1) begin
      errors++; $display("FAIL size11: mis=%0b reads=%0d lat=%0d required 1/0/1", mis, nrd, lat);
    end
    do_req(1'b0, 2'b01, 1'b0, 32'h401, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (mis !== 1'b1 || oob !== 1'b0) begin
      errors++; $display("FAIL mis_before_oob: mis=%0b oob=%0b required 1/0", mis, oob);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (oob !== 1'b0 || mis !== 1'b0 || lat !== 2 || rd !== 32'h0) begin
      errors++; $display("FAIL top_word_in_range: oob=%0b mis=%0b lat=%0d rdata=%h required 0/0/2/0", oob, mis, lat, rd);
    end
  endtask

  task automatic test_reset_during_write();
    logic [31:0] rd, wa, wdt; logic mis, oob; int lat, nrd, nwr;
    @(negedge clk);
    req_write = 1'b1; req_size = 2'b01; req_signed = 1'b0; req_addr = 32'h10; req_wdata = 32'h0000_1234;
    req_valid = 1'b1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++; $display("FAIL sh_ready: got %0b required 1", req_ready);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_read !== 1'b1) begin
      errors++; $display("FAIL sh_read_phase: mem_read=%0b required 1", mem_read);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (mem_write !== 1'b0) begin
      errors++; $display("FAIL write_under_reset: mem_write=%0b required 0", mem_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      errors++; $display("FAIL idle_after_reset: ready=%0b resp_valid=%0b required 1/0", req_ready, resp_valid);
    end
    do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, rd, mis, oob, lat, nrd, nwr, wa, wdt);
    checks++;
    if (rd !== 32'hDEAD_55EF) begin
      errors++; $display("FAIL dropped_write: rdata=%h required dead55ef", rd);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    test_reset();
    test_word_store_load();
    test_subword_loads();
    test_byte_store_rmw();
    test_errors();
    test_reset_during_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
